// File: rtl/seven_seg_reader_pkg.sv
// Shared definitions for the seven-segment reader: FSM encoding, the
// segment-pattern table shared with the display decoder, and strobe helpers.
package seven_seg_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StHold
  } state_e;

  localparam int unsigned NumPatterns = 16;

  // Active-low {A..G} pattern for each hex digit, indexed by nibble value.
  localparam logic [6:0] SegPatterns [NumPatterns] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  function automatic logic strobe_valid(input logic [3:0] an_n);
    return $onehot(~an_n);
  endfunction

  function automatic logic [1:0] strobe_index(input logic [3:0] an_n);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (!an_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational reverse lookup: active-low segment pattern to hex nibble,
// flagging patterns that are not one of the sixteen hex glyphs.
module seg_pattern_lookup (
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal
);
  import seven_seg_reader_pkg::*;

  always_comb begin
    nibble = '0;
    legal  = 1'b0;
    for (int i = 0; i < NumPatterns; i++) begin
      if (pattern == SegPatterns[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Recovers the four hex digits shown on a multiplexed seven-segment display.
// Define SEVEN_SEG_READER_DP_EN to also capture the per-digit decimal point.
module seven_seg_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
`ifdef SEVEN_SEG_READER_DP_EN
  input  logic        dp_n,
  output logic [3:0]  dp,
`endif
  input  logic        clear,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        pattern_err
);
  import seven_seg_reader_pkg::*;

`ifdef SEVEN_SEG_READER_DP_EN
  localparam int unsigned SegW = 8;
  logic [SegW-1:0] seg_raw;
  assign seg_raw = {dp_n, seg_n};
`else
  localparam int unsigned SegW = 7;
  logic [SegW-1:0] seg_raw;
  assign seg_raw = seg_n;
`endif

  localparam int unsigned SampW = SegW + 4;
  localparam logic [7:0]  StableCnt = 8'(STABLE_CYCLES);

  // Sample layout: {an_n, [dp_n,] seg_n}
  logic [SampW-1:0] sync1_q, sync2_q, prev_q;
  state_e           state_q;
  logic [7:0]       cnt_q;

  logic [3:0]  an_s;
  logic [6:0]  seg_s;
  logic        strobed;
  logic [1:0]  digit;
  logic        same;
  logic [3:0]  lk_nibble;
  logic        lk_legal;
  logic [15:0] value_upd;
  logic [3:0]  valid_upd;

  assign an_s    = sync2_q[SampW-1 -: 4];
  assign seg_s   = sync2_q[6:0];
  assign strobed = strobe_valid(an_s);
  assign digit   = strobe_index(an_s);
  assign same    = (sync2_q == prev_q);

  seg_pattern_lookup u_lookup (
    .pattern (seg_s),
    .nibble  (lk_nibble),
    .legal   (lk_legal)
  );

  always_comb begin
    value_upd = value;
    valid_upd = digit_valid;
    if (lk_legal) value_upd[4*digit +: 4] = lk_nibble;
    valid_upd[digit] = lk_legal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      prev_q      <= '1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      value       <= '0;
      digit_valid <= '0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
`ifdef SEVEN_SEG_READER_DP_EN
      dp          <= '0;
`endif
    end else begin
      sync1_q     <= {an_n, seg_raw};
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      frame_valid <= 1'b0;
      if (clear) begin
        state_q     <= StIdle;
        cnt_q       <= '0;
        value       <= '0;
        digit_valid <= '0;
        pattern_err <= 1'b0;
`ifdef SEVEN_SEG_READER_DP_EN
        dp          <= '0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (strobed) begin
              state_q <= StTrack;
              cnt_q   <= 8'd1;
            end
          end
          StTrack: begin
            if (!strobed) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (!same) begin
              cnt_q <= 8'd1;
            end else if (cnt_q == StableCnt) begin
              // Window complete: capture the digit and wait for the display to move on.
              state_q <= StHold;
              if (lk_legal) value <= value_upd;
              else          pattern_err <= 1'b1;
              if (valid_upd == 4'hF) begin
                frame_valid <= 1'b1;
                digit_valid <= '0;
              end else begin
                digit_valid <= valid_upd;
              end
`ifdef SEVEN_SEG_READER_DP_EN
              dp[digit] <= ~sync2_q[7];
`endif
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StHold: begin
            if (!same) begin
              if (strobed) begin
                state_q <= StTrack;
                cnt_q   <= 8'd1;
              end else begin
                state_q <= StIdle;
                cnt_q   <= '0;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: directed scenarios plus random
// display traffic compared against a run-length reference model.
module tb_seven_seg_reader;

  localparam int unsigned STABLE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        clear;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        pattern_err;
`ifdef SEVEN_SEG_READER_DP_EN
  logic        dp_n = 1'b1;
  logic [3:0]  dp;
`endif

  seven_seg_reader #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .an_n        (an_n),
`ifdef SEVEN_SEG_READER_DP_EN
    .dp_n        (dp_n),
    .dp          (dp),
`endif
    .clear       (clear),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .pattern_err (pattern_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int frames = 0;

  logic [6:0] pat_tab [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  // Reference model: raw inputs seen at the last three edges, and the length of
  // the current run of identical strobed samples.
  logic [10:0] hist [3];
  logic [10:0] prev_s;
  int          run;
  logic [15:0] m_value;
  logic [3:0]  m_valid;
  logic        m_frame;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = '1;
    prev_s  = '1;
    run     = 0;
    m_value = '0;
    m_valid = '0;
    m_frame = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge();
    logic [10:0] s;
    int nz, d, nib;
    bit found;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {an_n, seg_n};
    s = hist[2];
    m_frame = 1'b0;
    nz = 0;
    d  = 0;
    for (int i = 0; i < 4; i++) begin
      if (!s[7+i]) begin
        nz++;
        d = i;
      end
    end
    if (clear) begin
      run = 0;
      m_value = '0;
      m_valid = '0;
      m_err   = 1'b0;
    end else if (nz != 1) begin
      run = 0;
    end else begin
      if (s == prev_s && run > 0) run++;
      else run = 1;
      if (run == STABLE + 1) begin
        found = 0;
        nib = 0;
        for (int i = 0; i < 16; i++) begin
          if (pat_tab[i] == s[6:0]) begin
            found = 1;
            nib = i;
          end
        end
        if (found) begin
          m_value[4*d +: 4] = 4'(nib);
          m_valid[d] = 1'b1;
          if (m_valid == 4'hF) begin
            m_frame = 1'b1;
            m_valid = '0;
          end
        end else begin
          m_valid[d] = 1'b0;
          m_err = 1'b1;
        end
      end
    end
    prev_s = s;
  endtask

  task automatic check_outputs();
    check("value", 32'(value), 32'(m_value));
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("frame_valid", 32'(frame_valid), 32'(m_frame));
    check("pattern_err", 32'(pattern_err), 32'(m_err));
  endtask

  // Advance n clocks; called at a negedge, returns at a negedge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (frame_valid === 1'b1) frames++;
      check_outputs();
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    an_n  = an;
    seg_n = seg;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    model_reset();
    check("async_reset_value", 32'(value), 32'h0);
    check("async_reset_valid", 32'(digit_valid), 32'h0);
    check("async_reset_err", 32'(pattern_err), 32'h0);
    check("async_reset_frame", 32'(frame_valid), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int f0;
    reset = 1'b1;
    clear = 1'b0;
    drive(4'hF, 7'h7F);
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;
    cyc(3);

    // Single digit latency
    drive(4'b1110, 7'h12);
    cyc(6);
    check("latency_early", 32'(value[3:0]), 32'h0);
    cyc(1);
    check("latency_value", 32'(value[3:0]), 32'h2);
    check("latency_valid", 32'(digit_valid), 32'h1);
    check("latency_err", 32'(pattern_err), 32'h0);
    cyc(3);
    drive(4'hF, 7'h7F);
    cyc(3);

    // Full frame
    pulse_clear();
    f0 = frames;
    drive(4'b1110, 7'h06); cyc(8);
    drive(4'b1101, 7'h4C); cyc(8);
    drive(4'b1011, 7'h24); cyc(8);
    drive(4'b0111, 7'h01); cyc(8);
    check("frame_value", 32'(value), 32'h0543);
    check("frame_pulses", 32'(frames - f0), 32'd1);
    check("frame_valid_cleared", 32'(digit_valid), 32'h0);
    drive(4'hF, 7'h7F); cyc(3);

    // Unstable segments never latch
    pulse_clear();
    for (int i = 0; i < 6; i++) begin
      drive(4'b1110, (i % 2 == 0) ? 7'h12 : 7'h06);
      cyc(2);
    end
    check("toggle_value", 32'(value), 32'h0);
    check("toggle_valid", 32'(digit_valid), 32'h0);

    // Illegal pattern on digit 1 after a good digit 1
    drive(4'b1101, 7'h4F); cyc(8);
    drive(4'b1101, 7'h7F); cyc(8);
    check("illegal_err", 32'(pattern_err), 32'h1);
    check("illegal_valid", 32'(digit_valid[1]), 32'h0);
    check("illegal_value", 32'(value), 32'h0010);
    drive(4'hF, 7'h7F); cyc(5);
    check("illegal_sticky", 32'(pattern_err), 32'h1);
    pulse_clear();
    check("clear_err", 32'(pattern_err), 32'h0);

    // Two strobes at once, then reset mid-track
    drive(4'b1100, 7'h12); cyc(8);
    check("multi_strobe_valid", 32'(digit_valid), 32'h0);
    drive(4'b1011, 7'h06); cyc(8);
    drive(4'b1110, 7'h12); cyc(4);
    do_reset();
    cyc(6);
    check("post_reset_early", 32'(digit_valid), 32'h0);
    cyc(1);
    check("post_reset_latch", 32'(digit_valid), 32'h1);
    drive(4'hF, 7'h7F); cyc(3);

    // Clear on the frame-completing latch edge
    pulse_clear();
    f0 = frames;
    drive(4'b1110, 7'h06); cyc(8);
    drive(4'b1101, 7'h4C); cyc(8);
    drive(4'b1011, 7'h24); cyc(8);
    drive(4'b0111, 7'h01); cyc(6);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clear_frame_pulses", 32'(frames - f0), 32'd0);
    check("clear_frame_value", 32'(value), 32'h0);
    check("clear_frame_valid", 32'(digit_valid), 32'h0);
    cyc(10);

    // Random display traffic
    for (int p = 0; p < 200; p++) begin
      logic [3:0] an;
      logic [6:0] seg;
      if ($urandom_range(0, 9) < 8) begin
        an = 4'hF;
        an[$urandom_range(0, 3)] = 1'b0;
      end else begin
        an = 4'($urandom);
      end
      if ($urandom_range(0, 3) != 0) seg = pat_tab[$urandom_range(0, 15)];
      else seg = 7'($urandom);
      drive(an, seg);
      if ($urandom_range(0, 19) == 0) pulse_clear();
      cyc($urandom_range(1, 10));
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_reader.md
SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive identical synchronized samples required before a digit is latched; legal range 2..255.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 Port list (clock and reset first):
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- seg_n  in  7  active-low segment lines {A,B,C,D,E,F,G}, A = MSB.
- an_n  in  4  active-low digit strobes; bit d selects digit d.
- clear  in  1  synchronous clear pulse.
- value  out  16  decoded hex digits; digit d in value[4d+3:4d].
- digit_valid  out  4  digit d captured with a legal pattern in the current frame.
- frame_valid  out  1  one-cycle pulse when all four digits have been captured.
- pattern_err  out  1  sticky flag: an unrecognized segment pattern was latched.

Function
REQ-004 seg_n and an_n SHALL pass through a 2-flop synchronizer; all logic below uses the stage-2 sample S = {an_n, seg_n}.
REQ-005 A sample is "strobed" when exactly one an_n bit is 0; the digit index d is the position of that 0.
REQ-006 The FSM SHALL have three states: IDLE, TRACK and HOLD.
REQ-007 IDLE -> TRACK when S is strobed; the stability counter loads 1.
REQ-008 TRACK:
- S equal to the previous S -> counter increments.
- S strobed but different -> counter reloads 1.
- S not strobed -> IDLE.
REQ-009 TRACK -> HOLD on the edge where the counter reaches STABLE_CYCLES; the digit latches on that same edge.
REQ-010 HOLD: stay while S is unchanged. When S changes -> TRACK with the counter at 1 if S is strobed; otherwise -> IDLE.
REQ-011 Latch lookup of seg_n (hex {A..G}) -> nibble:
- 01->0, 4F->1, 12->2, 06->3, 4C->4, 24->5, 20->6, 0F->7
- 00->8, 04->9, 08->A, 60->B, 31->C, 42->D, 30->E, 38->F
REQ-012 Legal pattern: write the nibble to value digit d and set digit_valid[d].
REQ-013 Illegal pattern: value is unchanged, digit_valid[d] is cleared, and pattern_err is set.
REQ-014 Latency: with raw inputs constant from before clock edge k, the latch SHALL be visible after edge k+STABLE_CYCLES+2.
REQ-015 A latch that makes digit_valid == 4'hF SHALL pulse frame_valid for one cycle and clear digit_valid to 0 on the same edge; value is retained.
REQ-016 Re-latching an already-valid digit SHALL overwrite its nibble and SHALL NOT pulse frame_valid unless all four bits become set.
REQ-017 clear=1: FSM -> IDLE, counter=0, value=0, digit_valid=0, pattern_err=0, frame_valid=0. clear wins over a simultaneous latch.

Reset
REQ-018 On reset assertion, immediately and asynchronously:
- synchronizers to all-ones; FSM to IDLE; counter to 0;
- value=16'h0000, digit_valid=4'h0, frame_valid=0, pattern_err=0.
REQ-019 Reset asserted mid-TRACK SHALL discard the partial count. The first latch after release needs a full STABLE_CYCLES window.

Configuration
REQ-020 Macro SEVEN_SEG_READER_DP_EN selects decimal-point capture.
- Defined: add input dp_n (1, active-low, synchronized with seg_n) and output dp (4). dp[d] = ~dp_n at each digit-d latch; dp is included in the stability comparison; dp resets and clears to 0.
- Undefined: neither port exists and behaviour is as above.

Structure
REQ-021 The shared package SHALL hold:
- the FSM state encoding;
- the 16-entry segment-pattern constants used by both the existing decoder and this block.
REQ-022 The pattern-to-nibble lookup SHALL be a combinational sub-module seg_pattern_lookup (7-bit in; 4-bit nibble and legal flag out). The FSM, counter and registers stay in the top level.

Verification
REQ-023 an_n=4'b1110, seg_n=7'h12, held 10 cycles -> after edge k+6 value[3:0]=2, digit_valid=4'b0001, pattern_err=0.
REQ-024 Digits 0..3 each held 8 cycles with patterns 06,4C,24,01 -> value=16'h0543, one frame_valid pulse, digit_valid returns to 0.
REQ-025 seg_n toggles 12/06 every 2 cycles on digit 0 (STABLE_CYCLES=4) -> no latch; digit_valid and value unchanged.
REQ-026 Digit 1 with seg_n=7'h7F held 8 cycles -> pattern_err=1, digit_valid[1]=0, value unchanged; stays set until clear.
REQ-027 an_n=4'b1100, held 8 cycles -> no latch. Then reset during TRACK on a legal digit -> all outputs 0 immediately; after release the latch needs a full window.
REQ-028 clear asserted on the latch edge of digit 3 completing a frame -> no frame_valid; value=0; digit_valid=0.
